// File: rtl/pstats_event_gen.sv
// Per-channel event-pulse generator for port-statistics self-test: staggered periodic or
// LFSR-gated random pulses over a bounded run, with abort, drain and an emitted-event counter.
module pstats_event_gen #(
  parameter int          g_num_ports   = 10,
  parameter int          g_cnt_width   = 16,
  parameter int          g_pulse_width = 1,
  parameter int          g_stagger     = 1,
  parameter logic [15:0] g_lfsr_seed   = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   mode_i,
  input  logic [g_cnt_width-1:0] period_i,
  input  logic [7:0]             thresh_i,
  input  logic [15:0]            limit_i,
  output logic [g_num_ports-1:0] trig_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            evt_cnt_o
);

  localparam int PCW = (g_pulse_width < 2) ? 1 : $clog2(g_pulse_width + 1);
  localparam logic [PCW-1:0] PULSE_LEN = PCW'(g_pulse_width);
  localparam logic [g_cnt_width-1:0] MIN_PERIOD = g_cnt_width'(g_pulse_width + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state;
  logic [g_cnt_width-1:0]   period_r;
  logic                     mode_r;
  logic [7:0]               thresh_r;
  logic [15:0]              limit_r;
  logic [g_cnt_width-1:0]   pcnt;
  logic [15:0]              rounds;
  logic [PCW-1:0]           pc [g_num_ports];
  logic [15:0]              lfsr;

  logic [g_num_ports-1:0]   fire;
  logic [31:0]              fire_cnt;
  logic                     pulses_idle;
  logic [7:0]               rnd;
  logic                     wrap;
  logic [32:0]              evt_sum;

  // Low byte of the LFSR rotated left by sh, so each channel sees a different slice.
  function automatic logic [7:0] rot_byte(input logic [15:0] v, input int sh);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[(b + 16 - sh) % 16];
    return r;
  endfunction

  assign wrap    = (pcnt == period_r - 1'b1);
  assign evt_sum = {1'b0, evt_cnt_o} + {1'b0, fire_cnt};

  // A stop in the current cycle also suppresses that cycle's slots: abort means no new pulses.
  always_comb begin
    fire        = '0;
    fire_cnt    = '0;
    pulses_idle = 1'b1;
    rnd         = '0;
    for (int n = 0; n < g_num_ports; n++) begin
      rnd = rot_byte(lfsr, n % 16);
      if (state == RUN && !stop_i && 32'(pcnt) == 32'(n * g_stagger) &&
          (!mode_r || rnd < thresh_r))
        fire[n] = 1'b1;
      if (pc[n] != '0) pulses_idle = 1'b0;
      fire_cnt = fire_cnt + 32'(fire[n]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      period_r  <= MIN_PERIOD;
      mode_r    <= 1'b0;
      thresh_r  <= '0;
      limit_r   <= '0;
      pcnt      <= '0;
      rounds    <= '0;
      lfsr      <= g_lfsr_seed;
      trig_o    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      evt_cnt_o <= '0;
      for (int n = 0; n < g_num_ports; n++) pc[n] <= '0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      done_o <= 1'b0;

      // A slot on a channel that is still high simply reloads its width counter.
      for (int n = 0; n < g_num_ports; n++) begin
        if (fire[n]) begin
          pc[n]     <= PULSE_LEN;
          trig_o[n] <= 1'b1;
        end else if (pc[n] != '0) begin
          pc[n]     <= pc[n] - PCW'(1);
          trig_o[n] <= (pc[n] != PCW'(1));
        end else begin
          trig_o[n] <= 1'b0;
        end
      end

      evt_cnt_o <= evt_sum[32] ? 32'hFFFF_FFFF : evt_sum[31:0];

      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= RUN;
            period_r  <= (period_i < MIN_PERIOD) ? MIN_PERIOD : period_i;
            mode_r    <= mode_i;
            thresh_r  <= thresh_i;
            limit_r   <= limit_i;
            pcnt      <= '0;
            rounds    <= '0;
            evt_cnt_o <= '0;
            busy_o    <= 1'b1;
          end
        end
        RUN: begin
          if (stop_i) begin
            state <= DRAIN;
          end else if (wrap) begin
            pcnt   <= '0;
            rounds <= rounds + 16'd1;
            if (limit_r != '0 && rounds == limit_r - 16'd1) state <= DRAIN;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (pulses_idle) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pstats_event_gen.sv
// Directed bench for pstats_event_gen: one instance with 1-cycle pulses, one with 4-cycle pulses.
module tb_pstats_event_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, stop_a, stop_b, mode;
  logic [15:0] period, limit;
  logic [7:0]  thresh;
  logic [3:0]  trig_a, trig_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] evt_a, evt_b;

  int          total = 0;
  int          bad   = 0;

  logic [63:0] tm [4];
  logic [63:0] bm, dm;
  logic [3:0]  trig_or;
  int          done_cnt;
  logic [31:0] evt_end;

  always #5 clk = ~clk;

  pstats_event_gen #(.g_num_ports(4), .g_cnt_width(16), .g_pulse_width(1),
                     .g_stagger(1), .g_lfsr_seed(16'hACE1)) u_w1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .stop_i(stop_a), .mode_i(mode),
    .period_i(period), .thresh_i(thresh), .limit_i(limit),
    .trig_o(trig_a), .busy_o(busy_a), .done_o(done_a), .evt_cnt_o(evt_a));

  pstats_event_gen #(.g_num_ports(4), .g_cnt_width(16), .g_pulse_width(4),
                     .g_stagger(1), .g_lfsr_seed(16'hACE1)) u_w4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .stop_i(stop_b), .mode_i(mode),
    .period_i(period), .thresh_i(thresh), .limit_i(limit),
    .trig_o(trig_b), .busy_o(busy_b), .done_o(done_b), .evt_cnt_o(evt_b));

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Start a run on instance b (0: W=1, 1: W=4); k counts cycles after the start edge.
  task automatic run(input bit b, input logic [15:0] per, input logic [15:0] lim,
                     input bit md, input logic [7:0] th, input int ncyc,
                     input int stop_at, input int start_at);
    logic [3:0] t;
    @(negedge clk);
    period = per; limit = lim; mode = md; thresh = th;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 4; n++) tm[n] = '0;
    bm = '0; dm = '0; trig_or = '0; done_cnt = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start_a = !b && (k == start_at);
      start_b =  b && (k == start_at);
      stop_a  = !b && (k == stop_at);
      stop_b  =  b && (k == stop_at);
      t = b ? trig_b : trig_a;
      if (k < 64) begin
        for (int n = 0; n < 4; n++) tm[n][k] = t[n];
        bm[k] = b ? busy_b : busy_a;
        dm[k] = b ? done_b : done_a;
      end
      if (b ? done_b : done_a) done_cnt++;
      trig_or |= t;
    end
    evt_end = b ? evt_b : evt_a;
  endtask

  task automatic check_run(input string nm, input logic [63:0] e0, input logic [63:0] e1,
                           input logic [63:0] e2, input logic [63:0] e3,
                           input logic [63:0] eb, input logic [63:0] ed, input logic [31:0] ee);
    logic [63:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int n = 0; n < 4; n++) begin
      total++;
      if (tm[n] !== ex[n]) begin
        bad++;
        $display("FAIL %s trig[%0d]: got %h want %h", nm, n, tm[n], ex[n]);
      end
    end
    total++;
    if (bm !== eb) begin bad++; $display("FAIL %s busy: got %h want %h", nm, bm, eb); end
    total++;
    if (dm !== ed) begin bad++; $display("FAIL %s done: got %h want %h", nm, dm, ed); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL %s done_count: got %0d want 1", nm, done_cnt); end
    total++;
    if (evt_end !== ee) begin bad++; $display("FAIL %s evt_cnt: got %0d want %0d", nm, evt_end, ee); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({trig_a, busy_a, done_a, evt_a} !== 38'd0) begin
      bad++; $display("FAIL reset_w1: got %h want 0", {trig_a, busy_a, done_a, evt_a});
    end
    total++;
    if ({trig_b, busy_b, done_b, evt_b} !== 38'd0) begin
      bad++; $display("FAIL reset_w4: got %h want 0", {trig_b, busy_b, done_b, evt_b});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // period 8, limit 3: ch n high at k = 2+n, 10+n, 18+n; drain at 25, done at 26.
  task automatic test_periodic(input string nm);
    run(1'b0, 16'd8, 16'd3, 1'b0, 8'd0, 40, 0, 0);
    check_run(nm, rng(2,2) | rng(10,10) | rng(18,18), rng(3,3) | rng(11,11) | rng(19,19),
              rng(4,4) | rng(12,12) | rng(20,20), rng(5,5) | rng(13,13) | rng(21,21),
              rng(1,25), rng(26,26), 32'd12);
    repeat (5) @(negedge clk);
    total++;
    if (evt_a !== 32'd12) begin bad++; $display("FAIL %s evt_hold: got %0d want 12", nm, evt_a); end
  endtask

  // Offset 3 is outside a 3-cycle period; ch2's last pulse keeps DRAIN open one extra cycle.
  task automatic test_short_period();
    run(1'b0, 16'd3, 16'd2, 1'b0, 8'd0, 20, 0, 0);
    check_run("short_period", rng(2,2) | rng(5,5), rng(3,3) | rng(6,6), rng(4,4) | rng(7,7),
              64'd0, rng(1,8), rng(9,9), 32'd6);
  endtask

  // period 1 with W=4 is raised to 5: four high, one low.
  task automatic test_min_period();
    run(1'b1, 16'd1, 16'd2, 1'b0, 8'd0, 25, 0, 0);
    check_run("min_period", rng(2,5) | rng(7,10), rng(3,6) | rng(8,11), rng(4,7) | rng(9,12),
              rng(5,8) | rng(10,13), rng(1,14), rng(15,15), 32'd8);
  endtask

  // Stop at k=3 (two cycles into ch0 pulse); start during DRAIN at k=5 must be ignored.
  task automatic test_stop_drain();
    run(1'b1, 16'd20, 16'd0, 1'b0, 8'd0, 20, 3, 5);
    check_run("stop_drain", rng(2,5), rng(3,6), 64'd0, 64'd0, rng(1,7), rng(8,8), 32'd2);
  endtask

  task automatic test_random();
    run(1'b0, 16'd8, 16'd5, 1'b1, 8'd0, 50, 0, 0);
    total++;
    if (trig_or !== 4'd0) begin bad++; $display("FAIL rand_t0 trig: got %b want 0000", trig_or); end
    total++;
    if (evt_end !== 32'd0) begin bad++; $display("FAIL rand_t0 evt: got %0d want 0", evt_end); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL rand_t0 done: got %0d want 1", done_cnt); end

    run(1'b0, 16'd8, 16'd1000, 1'b1, 8'd255, 8010, 0, 0);
    total++;
    if (evt_end < 32'd3960 || evt_end > 32'd4000) begin
      bad++; $display("FAIL rand_t255 evt: got %0d want 3960..4000", evt_end);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL rand_t255 done: got %0d want 1", done_cnt); end

    run(1'b0, 16'd8, 16'd1000, 1'b1, 8'd128, 8010, 0, 0);
    total++;
    if (evt_end < 32'd1800 || evt_end > 32'd2200) begin
      bad++; $display("FAIL rand_t128 evt: got %0d want 1800..2200", evt_end);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL rand_t128 done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midrun();
    run(1'b0, 16'd8, 16'd3, 1'b0, 8'd0, 3, 0, 0);
    total++;
    if (trig_a !== 4'b0010 || evt_a !== 32'd2) begin
      bad++; $display("FAIL midrun_pre: got trig=%b evt=%0d want trig=0010 evt=2", trig_a, evt_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({trig_a, busy_a, evt_a} !== 37'd0) begin
      bad++; $display("FAIL midrun_reset: got %h want 0", {trig_a, busy_a, evt_a});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_periodic("after_reset");
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; stop_a = 1'b0; stop_b = 1'b0;
    mode = 1'b0; period = '0; limit = '0; thresh = '0;
    test_reset();
    test_periodic("periodic");
    test_short_period();
    test_min_period();
    test_stop_drain();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
